// File: rtl/imm_rotate_encoder.sv
// imm_rotate_encoder: sequential search for the {rotate_imm, imm8} immediate
// encoding of a 32-bit constant, such that ROR({24'b0, imm8}, 2*rotate_imm) == value.
// One rotation is tested per cycle, and the smallest matching rotation wins.
// Optional feature macro: IMM_INVERT_EN. When it is defined and the plain pass fails,
// a second pass searches for an encoding of ~value (MVN form) and reports it
// through 'inverted'.
module imm_rotate_encoder #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned ROT_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_LEN-1:0]   value,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic                  inverted,
    output logic [ROT_LEN+7:0]    shift_operand
);

    localparam int unsigned IMM_LEN = 8;
    localparam int unsigned SH_W    = ROT_LEN + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t               state;
    logic [DATA_LEN-1:0]  cand;
    logic [ROT_LEN-1:0]   rot;

    logic [SH_W-1:0]      lsh_c;
    logic [SH_W-1:0]      rsh_c;
    logic [DATA_LEN-1:0]  rot_val_c;
    logic                 hit_c;
    logic                 last_c;

    // Circular left rotate of the candidate by 2*rot; a right shift by the full width yields 0.
    always_comb begin
        lsh_c     = {1'b0, rot, 1'b0};
        rsh_c     = SH_W'(DATA_LEN) - lsh_c;
        rot_val_c = (cand << lsh_c) | (cand >> rsh_c);
        hit_c     = (rot_val_c[DATA_LEN-1:IMM_LEN] == '0);
        last_c    = (rot == '1);
    end

    // Search FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cand          <= '0;
            rot           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            found         <= 1'b0;
            shift_operand <= '0;
`ifdef IMM_INVERT_EN
            inverted      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cand          <= value;
                        rot           <= '0;
                        found         <= 1'b0;
                        shift_operand <= '0;
`ifdef IMM_INVERT_EN
                        inverted      <= 1'b0;
`endif
                        busy          <= 1'b1;
                        state         <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (hit_c) begin
                        shift_operand <= {rot, rot_val_c[IMM_LEN-1:0]};
                        found         <= 1'b1;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end else if (last_c) begin
`ifdef IMM_INVERT_EN
                        // The inverted flag doubles as the "second pass active" marker.
                        if (!inverted) begin
                            cand     <= ~cand;
                            rot      <= '0;
                            inverted <= 1'b1;
                        end else begin
                            found         <= 1'b0;
                            inverted      <= 1'b0;
                            shift_operand <= '0;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            state         <= DONE;
                        end
`else
                        found         <= 1'b0;
                        shift_operand <= '0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
`endif
                    end else begin
                        rot <= rot + ROT_LEN'(1);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef IMM_INVERT_EN
    assign inverted = 1'b0;
`endif

endmodule

// File: tb/tb_imm_rotate_encoder.sv
// Testbench for imm_rotate_encoder: directed cases plus randomized values checked
// against a behavioural encoder model. Honours IMM_INVERT_EN like the design.
module tb_imm_rotate_encoder;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        found;
    logic        inverted;
    logic [11:0] shift_operand;

    int checks   = 0;
    int failures = 0;

    imm_rotate_encoder #(.DATA_LEN(32), .ROT_LEN(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .value         (value),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .inverted      (inverted),
        .shift_operand (shift_operand)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rol32(input logic [31:0] v, input int s);
        return (v << s) | (v >> ((32 - s) % 32));
    endfunction

    // Reference: scan rotations in ascending order, first plain then (optionally) inverted.
    function automatic void model(input logic [31:0] v, output int lat, output bit f,
                                  output bit inv, output logic [11:0] so);
        logic [31:0] t;
        f = 0; inv = 0; so = '0; lat = 16;
        for (int r = 0; r < 16; r++) begin
            t = rol32(v, 2 * r);
            if (t < 32'd256) begin
                f = 1; so = {4'(r), t[7:0]}; lat = r + 1;
                return;
            end
        end
`ifdef IMM_INVERT_EN
        lat = 32;
        for (int r = 0; r < 16; r++) begin
            t = rol32(~v, 2 * r);
            if (t < 32'd256) begin
                f = 1; inv = 1; so = {4'(r), t[7:0]}; lat = 17 + r;
                return;
            end
        end
`endif
    endfunction

    // One transaction: accept at E0, measure done latency, check results and pulse width.
    task automatic run_case(input string tag, input logic [31:0] v, input int exp_lat,
                            input bit exp_f, input bit exp_inv, input logic [11:0] exp_so,
                            input bit poke);
        int lat;
        int extra;
        lat = 0;
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
        value = $urandom;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
            if (k == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (poke && k == 2) start = 1'b1;
            if (poke && k == 3) start = 1'b0;
        end
        start = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_found"}, 32'(found), 32'(exp_f));
        check({tag, "_inv"}, 32'(inverted), 32'(exp_inv));
        check({tag, "_so"}, 32'(shift_operand), 32'(exp_so));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done), 32'd0);
        if (poke) begin
            extra = 0;
            for (int k = 0; k < 20; k++) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            check({tag, "_extra_done"}, 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int          lat;
        bit          f;
        bit          inv;
        logic [11:0] so;
        logic [31:0] v;
        int          seen;

        rst   = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_found", 32'(found), 32'd0);
        check("rst_inv", 32'(inverted), 32'd0);
        check("rst_so", 32'(shift_operand), 32'd0);

        // Reset in the middle of a search aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1;
        value = 32'h0000_0101;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_found", 32'(found), 32'd0);
        check("midrst_so", 32'(shift_operand), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);

        // Directed cases.
        run_case("ff",       32'h0000_00FF, 1,  1'b1, 1'b0, 12'h0FF, 1'b0);
        run_case("ff000000", 32'hFF00_0000, 5,  1'b1, 1'b0, 12'h4FF, 1'b1);
        run_case("f000000f", 32'hF000_000F, 3,  1'b1, 1'b0, 12'h2FF, 1'b0);
        run_case("3fc",      32'h0000_03FC, 16, 1'b1, 1'b0, 12'hFFF, 1'b1);
        run_case("zero",     32'h0000_0000, 1,  1'b1, 1'b0, 12'h000, 1'b0);
`ifdef IMM_INVERT_EN
        run_case("101",      32'h0000_0101, 32, 1'b0, 1'b0, 12'h000, 1'b1);
        run_case("ffffff00", 32'hFFFF_FF00, 17, 1'b1, 1'b1, 12'h0FF, 1'b0);
`else
        run_case("101",      32'h0000_0101, 16, 1'b0, 1'b0, 12'h000, 1'b1);
        run_case("ffffff00", 32'hFFFF_FF00, 16, 1'b0, 1'b0, 12'h000, 1'b0);
`endif

        // start held high: accepts every third edge (SEARCH hit, DONE, IDLE accept).
        @(negedge clk);
        start = 1'b1;
        value = 32'h0000_0000;
        @(posedge clk);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            check("b2b_done", 32'(done), 32'((k % 3) == 1));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);

        // Randomized values: encodable, inverted-encodable, arbitrary and small.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: v = rol32(32'($urandom_range(0, 255)), 32 - 2 * $urandom_range(0, 15));
                1: v = ~rol32(32'($urandom_range(0, 255)), 32 - 2 * $urandom_range(0, 15));
                2: v = $urandom;
                default: v = 32'($urandom_range(0, 1023));
            endcase
            model(v, lat, f, inv, so);
            run_case("rnd", v, lat, f, inv, so, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_rotate_encoder.md
Name: imm_rotate_encoder

Overview:
- Sequential inverse of the data-processing immediate decode. Given a 32-bit constant, it searches for the `rotate_imm`/`imm8` pair such that `ROR({24'b0, imm8}, 2*rotate_imm) == value`.
- Returns the pair as a 12-bit `shift_operand` field.
- Used by the instruction-generation/test-program path, which emits immediate-form instructions. Its output feeds the ID-stage shift_operand decode unchanged.

Parameters:
- DATA_LEN, 32, operand width. Must equal `REGISTER_FILE_LEN.
- ROT_LEN, 4, rotate_imm width. Search covers 2**ROT_LEN rotations.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request. Sampled only in IDLE.
- value  in  DATA_LEN  constant to encode. Captured on the accepted start edge.
- busy  out  1  high while in SEARCH
- done  out  1  one-cycle pulse when the result is valid
- found  out  1  encoding exists. Valid with done, held until the next accept.
- inverted  out  1  encoding is of ~value (MVN form). Constant 0 unless IMM_INVERT_EN is defined.
- shift_operand  out  12  {rotate_imm[3:0], imm8[7:0]}. Valid with done, held until the next accept.

Behaviour:
- Reset: synchronous, active-high, on rising clk. Values after reset:
  - state = IDLE
  - busy = 0, done = 0, found = 0, inverted = 0
  - shift_operand = 12'h000, rot counter = 0
  - Reset during SEARCH aborts the search; no done pulse follows.
- States are IDLE, SEARCH, DONE.
- IDLE:
  - If start = 1 at an edge: latch value into `cand`, rot = 0, clear found/inverted/shift_operand, go to SEARCH.
  - If start = 0: stay.
- SEARCH, one rotation tested per cycle:
  - Compute `t = ROL(cand, 2*rot)`, 32-bit circular; ROL by 0 is identity.
  - If `t[31:8] == 0`: shift_operand <= {rot, t[7:0]}, found <= 1, go to DONE.
  - Else if rot == 15 (and no invert pass pending): found <= 0, shift_operand <= 0, go to DONE.
  - Else: rot <= rot + 1 (4-bit; never wraps within a pass).
- DONE: done = 1 for exactly one cycle, then IDLE. busy = 0.
- Priority: the smallest rot that matches wins. This gives a unique, deterministic encoding, e.g. value 0 gives rot 0, imm8 0.
- Latency: start accepted at edge E0; match at rot r latched at edge E(r+1); done high in the cycle following. Worst case without invert is 16 tests: done after E16.
- start while busy or in DONE is ignored; value changes after accept have no effect.
- start held continuously: a new request is accepted in the IDLE cycle after each done, giving back-to-back operation.
- busy is a registered decode of state == SEARCH.
- done, found, inverted and shift_operand are registered outputs with no combinational path from inputs.

Optional Feature:
- Macro: IMM_INVERT_EN.
- Defined:
  - If the plain pass fails at rot 15, cand <= ~cand, rot <= 0, inverted <= 1, and the search continues for up to 16 more tests.
  - A match sets found = 1 with inverted = 1.
  - Failure of both passes gives found = 0 and inverted = 0.
  - Worst-case done follows E32.
  - The plain pass always has priority over the inverted pass.
- Undefined: single pass only; inverted tied to 0; no extra state or logic.

Test Plan:
- rst mid-search: start value=32'h00000101, assert rst at the 3rd SEARCH cycle -> next cycle busy=0, done=0, found=0, shift_operand=0; no done pulse follows.
- value=32'h000000FF -> done after E1, found=1, shift_operand=12'h0FF, inverted=0.
- value=32'hFF000000 -> done after E5, shift_operand=12'h4FF. Also value=32'hF000000F -> done after E3, shift_operand=12'h2FF.
- value=32'h000003FC -> done after E16, shift_operand=12'hFFF. Also value=32'h00000000 -> done after E1, shift_operand=12'h000.
- value=32'h00000101 (no invert) -> done after E16, found=0, shift_operand=0. Pulse start again during busy -> ignored, exactly one done pulse.
- IMM_INVERT_EN defined, value=32'hFFFFFF00 -> done after E17, found=1, inverted=1, shift_operand=12'h0FF. value=32'h00000101 -> done after E32, found=0, inverted=0.
